// File: rtl/register_access_if.sv
// register_access_if: request/response handshake plus the i2c master per-byte control bundle
interface register_access_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_read;
  logic [6:0] req_dev_addr;
  logic [7:0] req_reg_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       rsp_err;
  logic       mode;
  logic       transfer_start;
  logic       transfer_continue;
  logic [7:0] data_tx;
  logic       transfer_ready;
  logic       transaction_complete;
  logic       ack;
  logic       start_err;
  logic       arbitration_err;
  logic       bus_clear;
  logic [7:0] data_rx;
  modport slave (
    input  req_valid, req_read, req_dev_addr, req_reg_addr, req_wdata,
    input  transfer_ready, transaction_complete, ack, start_err, arbitration_err, bus_clear, data_rx,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err,
    output mode, transfer_start, transfer_continue, data_tx
  );
  modport master (
    output req_valid, req_read, req_dev_addr, req_reg_addr, req_wdata,
    output transfer_ready, transaction_complete, ack, start_err, arbitration_err, bus_clear, data_rx,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_err,
    input  mode, transfer_start, transfer_continue, data_tx
  );
endinterface

// File: rtl/register_access.sv
// register_access: sequences one register read/write request into i2c master byte controls
module register_access #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input logic              clk_in,
  input logic              rst_n,
  register_access_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, BYTE, WAIT_IDLE} state_t;
  state_t        r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_read;
  logic [6:0]    r_dev;
  logic [7:0]    r_reg;
  logic [7:0]    r_wdata;
  logic          r_mode;
  logic          r_start;
  logic          r_cont;
  logic [7:0]    r_data_tx;
  logic          r_rsp_valid;
  logic [7:0]    r_rdata;
  logic          r_nack;
  logic          r_err;
  logic [1:0]    w_nidx;
  logic          w_last;
  logic          w_fault;
  logic          w_timeout;
  logic          w_nmode;
  logic          w_nstart;
  logic          w_ncont;
  logic [7:0]    w_ndata;
  assign bus.req_ready         = r_state == IDLE;
  assign bus.rsp_valid         = r_rsp_valid;
  assign bus.rsp_rdata         = r_rdata;
  assign bus.rsp_nack          = r_nack;
  assign bus.rsp_err           = r_err;
  assign bus.mode              = r_mode;
  assign bus.transfer_start    = r_start;
  assign bus.transfer_continue = r_cont;
  assign bus.data_tx           = r_data_tx;
  // Decode the controls of the byte after the current one; byte 0 is loaded on accept
  always_comb begin
    w_nidx    = r_idx + 2'd1;
    w_last    = r_idx == (r_read ? 2'd3 : 2'd2);
    w_fault   = bus.arbitration_err | bus.start_err | bus.bus_clear;
    w_timeout = r_state != IDLE && !bus.transaction_complete && !bus.transfer_ready
                && r_cnt == CW'(TIMEOUT_CYCLES - 1);
    w_nmode   = w_nidx == 2'd3;
    w_nstart  = r_read && w_nidx != 2'd3;
    w_ncont   = w_nidx == 2'd1 ? !r_read : w_nidx == 2'd2 ? r_read : 1'b0;
    w_ndata   = w_nidx == 2'd1 ? r_reg : w_nidx == 2'd2 ? (r_read ? {r_dev, 1'b1} : r_wdata) : 8'h00;
  end
  // Sequencer: error > NACK > byte done > bus ready, with a progress watchdog over all busy states
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_cnt <= '0;
      {r_read, r_dev, r_reg, r_wdata} <= '0;
      {r_mode, r_start, r_cont, r_data_tx} <= '0;
      {r_rsp_valid, r_rdata, r_nack, r_err} <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_cnt <= (r_state == IDLE || bus.transaction_complete || bus.transfer_ready) ? '0 : r_cnt + 1'b1;
      if (r_state == IDLE) begin
        if (bus.req_valid) begin
          r_read <= bus.req_read;
          r_dev <= bus.req_dev_addr;
          r_reg <= bus.req_reg_addr;
          r_wdata <= bus.req_wdata;
          {r_rdata, r_nack, r_err} <= '0;
          r_idx <= '0;
          {r_mode, r_start, r_cont, r_data_tx} <= {3'b011, bus.req_dev_addr, 1'b0};
          r_state <= LAUNCH;
        end
      end else if (w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_err <= 1'b1;
        {r_mode, r_start, r_cont, r_data_tx} <= '0;
        r_state <= IDLE;
      end else if (w_fault) begin
        r_err <= 1'b1;
        {r_mode, r_start, r_cont, r_data_tx} <= '0;
        r_state <= WAIT_IDLE;
      end else if (bus.ack) begin
        r_nack <= 1'b1;
        {r_start, r_cont} <= 2'b00;
        r_state <= WAIT_IDLE;
      end else if (bus.transaction_complete && r_state == BYTE) begin
        if (w_last) begin
          {r_start, r_cont} <= 2'b00;
          r_state <= WAIT_IDLE;
          if (r_read) r_rdata <= bus.data_rx;
        end else begin
          r_idx <= w_nidx;
          {r_mode, r_start, r_cont, r_data_tx} <= {w_nmode, w_nstart, w_ncont, w_ndata};
        end
      end else if (bus.transfer_ready && r_state == LAUNCH) begin
        r_idx <= '0;
        r_state <= BYTE;
      end else if (bus.transfer_ready && r_state == WAIT_IDLE) begin
        r_rsp_valid <= 1'b1;
        {r_mode, r_start, r_cont, r_data_tx} <= '0;
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_register_access.sv
// tb_register_access: directed register write/read/NACK/arbitration/timeout/reset vectors
module tb_register_access;
  logic clk_in = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [9:0] q_bytes[$];
  register_access_if bus();
  register_access #(.TIMEOUT_CYCLES(1000)) dut (.clk_in(clk_in), .rst_n(rst_n), .bus(bus));
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_tr();
    bus.transfer_ready = 1'b1;
    @(negedge clk_in);
    bus.transfer_ready = 1'b0;
  endtask

  task automatic pulse_tc(input logic [7:0] rx);
    bus.data_rx = rx;
    bus.transaction_complete = 1'b1;
    @(negedge clk_in);
    bus.transaction_complete = 1'b0;
  endtask

  task automatic send(input logic rd, input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk_in);
    check("req_ready_idle", bus.req_ready, 1'b1);
    bus.req_valid = 1'b1;
    bus.req_read = rd;
    bus.req_dev_addr = dev;
    bus.req_reg_addr = ra;
    bus.req_wdata = wd;
    @(negedge clk_in);
    bus.req_valid = 1'b0;
    check("req_ready_fall", bus.req_ready, 1'b0);
    check("byte0_ctl", {bus.transfer_start, bus.transfer_continue, bus.data_tx}, {2'b11, dev, 1'b0});
  endtask

  // Simple master: latches {start, mode, data_tx} per byte, stops on NACK or when the
  // previous byte had continue=0 and no (repeated) start is requested.
  task automatic master(input int nack_at, input int arb_at, input logic [7:0] rx);
    int i;
    logic prev_cont;
    logic stop;
    logic nacked;
    i = 0;
    stop = 1'b0;
    q_bytes.delete();
    repeat (2) @(negedge clk_in);
    pulse_tr();
    while (!stop && i < 8) begin
      q_bytes.push_back({bus.transfer_start, bus.mode, bus.data_tx});
      prev_cont = bus.transfer_continue;
      nacked = i == nack_at;
      if (i == arb_at) begin
        bus.arbitration_err = 1'b1;
        @(negedge clk_in);
        bus.arbitration_err = 1'b0;
        check("arb_zero", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 16'h0);
        stop = 1'b1;
      end else begin
        repeat (3) @(negedge clk_in);
        pulse_tc(rx);
        @(negedge clk_in);
        bus.ack = nacked;
        @(negedge clk_in);
        bus.ack = 1'b0;
        if (nacked) check("nack_forced_stop", {bus.transfer_start, bus.transfer_continue}, 2'b00);
        repeat (2) @(negedge clk_in);
        stop = nacked || (!prev_cont && !bus.transfer_start);
        i++;
      end
    end
    repeat (3) @(negedge clk_in);
    pulse_tr();
  endtask

  task automatic expect_rsp(input logic nack, input logic err, input logic [7:0] rdata);
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_nack", bus.rsp_nack, nack);
    check("rsp_err", bus.rsp_err, err);
    check("rsp_rdata", bus.rsp_rdata, rdata);
    @(negedge clk_in);
    check("rsp_pulse", bus.rsp_valid, 1'b0);
    check("idle_ready", bus.req_ready, 1'b1);
    check("idle_outs", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 16'h0);
  endtask

  task automatic expect_bytes(input int n, input logic [9:0] e0, input logic [9:0] e1,
                              input logic [9:0] e2, input logic [9:0] e3);
    logic [9:0] e[4];
    e = '{e0, e1, e2, e3};
    check("byte_count", 16'(q_bytes.size()), 16'(n));
    for (int k = 0; k < n && k < q_bytes.size(); k++) check("bus_byte", q_bytes[k], e[k]);
  endtask

  initial begin
    int n;
    {bus.req_valid, bus.req_read, bus.req_dev_addr, bus.req_reg_addr, bus.req_wdata} = '0;
    {bus.transfer_ready, bus.transaction_complete, bus.ack} = '0;
    {bus.start_err, bus.arbitration_err, bus.bus_clear, bus.data_rx} = '0;
    repeat (2) @(negedge clk_in);
    check("rst_ready", bus.req_ready, 1'b1);
    check("rst_rsp", {bus.rsp_valid, bus.rsp_nack, bus.rsp_err, bus.rsp_rdata}, 16'h0);
    check("rst_outs", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 16'h0);
    rst_n = 1'b1;
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    master(-1, -1, 8'h33);
    expect_rsp(1'b0, 1'b0, 8'h00);
    expect_bytes(3, 10'h2A0, 10'h010, 10'h0A5, 10'h000);
    send(1'b1, 7'h68, 8'h75, 8'h00);
    master(-1, -1, 8'h71);
    expect_rsp(1'b0, 1'b0, 8'h71);
    expect_bytes(4, 10'h2D0, 10'h275, 10'h2D1, 10'h100);
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    master(0, -1, 8'h00);
    expect_rsp(1'b1, 1'b0, 8'h00);
    expect_bytes(1, 10'h2A0, 10'h000, 10'h000, 10'h000);
    send(1'b0, 7'h50, 8'h10, 8'hA5);
    master(-1, 1, 8'h00);
    expect_rsp(1'b0, 1'b1, 8'h00);
    expect_bytes(2, 10'h2A0, 10'h010, 10'h000, 10'h000);
    send(1'b1, 7'h11, 8'h22, 8'h00);
    n = 0;
    do begin
      @(negedge clk_in);
      n++;
    end while (!bus.rsp_valid && n < 1100);
    check("timeout_cycles", 16'(n), 16'd1000);
    expect_rsp(1'b0, 1'b1, 8'h00);
    send(1'b1, 7'h68, 8'h75, 8'h00);
    repeat (2) @(negedge clk_in);
    pulse_tr();
    repeat (2) begin
      repeat (2) @(negedge clk_in);
      pulse_tc(8'h00);
    end
    check("mid_read_idx2", bus.data_tx, 8'hD1);
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 16'h0);
    check("async_rst_ready", bus.req_ready, 1'b1);
    @(negedge clk_in);
    rst_n = 1'b1;
    send(1'b0, 7'h2A, 8'h01, 8'h3C);
    master(-1, -1, 8'h00);
    expect_rsp(1'b0, 1'b0, 8'h00);
    expect_bytes(3, 10'h254, 10'h001, 10'h03C, 10'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
